// File: rtl/vending_machine_change_if.sv
// Coin-acceptor / dispenser bundle for the vending controller.
// master = acceptor and driver side, slave = controller.
interface vending_machine_change_if #(
  parameter int CW = 5
);
  logic [1:0]    coin;
  logic          cancel;
  logic          nw_pa;
  logic          busy;
  logic          coin_rej;
  logic          chg_dime;
  logic          chg_nickel;
  logic [CW-1:0] credit;

  modport master (
    output coin, cancel,
    input  nw_pa, busy, coin_rej, chg_dime, chg_nickel, credit
  );

  modport slave (
    input  coin, cancel,
    output nw_pa, busy, coin_rej, chg_dime, chg_nickel, credit
  );
endinterface

// File: rtl/vending_machine_change.sv
// Coin vending controller: credit accumulation, one-cycle vend, greedy dime/nickel payout.
// Latency: vend on the edge that reaches PRICE; outputs decode registered state only.
module vending_machine_change #(
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 20,
  parameter int CW         = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  vending_machine_change_if.slave   vm
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    PAYOUT = 2'd2
  } state_t;

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW:0]   MAX_C   = (CW+1)'(MAX_CREDIT);

  state_t        state_q;
  logic [CW-1:0] credit_q;
  logic          coin_rej_q;

  logic [CW:0]   coin_val;
  logic [CW:0]   sum;
  logic          coin_nz;

  always_comb begin
    coin_val = '0;
    case (vm.coin)
      2'b01:   coin_val = (CW+1)'(1);
      2'b10:   coin_val = (CW+1)'(2);
      2'b11:   coin_val = (CW+1)'(5);
      default: coin_val = '0;
    endcase
  end

  assign sum     = {1'b0, credit_q} + coin_val;
  assign coin_nz = |vm.coin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      coin_rej_q <= 1'b0;
    end else begin
      coin_rej_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vm.cancel) begin
            // cancel beats a coin presented in the same cycle
            coin_rej_q <= coin_nz;
            if (credit_q != '0) state_q <= PAYOUT;
          end else if (coin_nz) begin
            if (sum > MAX_C) begin
              coin_rej_q <= 1'b1;
            end else begin
              credit_q <= sum[CW-1:0];
              if (sum >= {1'b0, PRICE_C}) state_q <= VEND;
            end
          end
        end
        VEND: begin
          coin_rej_q <= coin_nz;
          credit_q   <= credit_q - PRICE_C;
          state_q    <= (credit_q > PRICE_C) ? PAYOUT : IDLE;
        end
        PAYOUT: begin
          coin_rej_q <= coin_nz;
          // one idle-credit cycle in PAYOUT before returning to IDLE
          if (credit_q == '0)
            state_q <= IDLE;
          else if (credit_q >= CW'(2))
            credit_q <= credit_q - CW'(2);
          else
            credit_q <= credit_q - CW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vm.nw_pa      = (state_q == VEND);
  assign vm.busy       = (state_q != IDLE);
  assign vm.coin_rej   = coin_rej_q;
  assign vm.chg_dime   = (state_q == PAYOUT) && (credit_q >= CW'(2));
  assign vm.chg_nickel = (state_q == PAYOUT) && (credit_q == CW'(1));
  assign vm.credit     = credit_q;

endmodule

// File: tb/tb_vending_machine_change.sv
// Bench for vending_machine_change: three parameterisations share one stimulus stream
// and are compared every cycle against a queue-of-expected-cycles model.
module tb_vending_machine_change;

  logic clk;
  logic rst;

  vending_machine_change_if #(.CW(5)) vif0 ();
  vending_machine_change_if #(.CW(5)) vif1 ();
  vending_machine_change_if #(.CW(5)) vif2 ();

  vending_machine_change #(.PRICE(3),  .MAX_CREDIT(20), .CW(5)) dut0 (.clk(clk), .rst(rst), .vm(vif0.slave));
  vending_machine_change #(.PRICE(12), .MAX_CREDIT(12), .CW(5)) dut1 (.clk(clk), .rst(rst), .vm(vif1.slave));
  vending_machine_change #(.PRICE(1),  .MAX_CREDIT(20), .CW(5)) dut2 (.clk(clk), .rst(rst), .vm(vif2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // observed outputs: {nw_pa, busy, coin_rej, chg_dime, chg_nickel, credit[4:0]}
  logic [9:0] obs [3];
  assign obs[0] = {vif0.nw_pa, vif0.busy, vif0.coin_rej, vif0.chg_dime, vif0.chg_nickel, vif0.credit};
  assign obs[1] = {vif1.nw_pa, vif1.busy, vif1.coin_rej, vif1.chg_dime, vif1.chg_nickel, vif1.credit};
  assign obs[2] = {vif2.nw_pa, vif2.busy, vif2.coin_rej, vif2.chg_dime, vif2.chg_nickel, vif2.credit};

  int price_p [3] = '{3, 12, 1};
  int maxc_p  [3] = '{20, 12, 20};

  typedef struct packed {
    logic       vend;
    logic       dime;
    logic       nick;
    logic [4:0] cred;
  } exp_t;

  // model: idle credit plus a precomputed list of busy cycles
  exp_t plan_m [3][16];
  int   plen [3];
  int   ppos [3];
  int   cred_m [3];
  bit   rej_m [3];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  function automatic logic [9:0] mk(bit nw, bit b, bit r, bit d, bit n, int c);
    return {nw, b, r, d, n, 5'(c)};
  endfunction

  function automatic logic [9:0] exp_vec(int i);
    exp_t e;
    if (ppos[i] < plen[i]) begin
      e = plan_m[i][ppos[i]];
      return {e.vend, 1'b1, rej_m[i], e.dime, e.nick, e.cred};
    end
    return {1'b0, 1'b0, rej_m[i], 1'b0, 1'b0, 5'(cred_m[i])};
  endfunction

  task automatic model_reset(int i);
    plen[i] = 0; ppos[i] = 0; cred_m[i] = 0; rej_m[i] = 1'b0;
  endtask

  task automatic add(int i, bit v, bit d, bit n, int c);
    exp_t e;
    e.vend = v; e.dime = d; e.nick = n; e.cred = 5'(c);
    plan_m[i][plen[i]] = e;
    plen[i]++;
  endtask

  task automatic add_payout(int i, int c);
    int r;
    r = c;
    while (r > 0) begin
      add(i, 1'b0, r >= 2, r == 1, r);
      r -= (r >= 2) ? 2 : 1;
    end
    add(i, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic model_edge(int i, logic [1:0] c, bit cn);
    int v;
    int s;
    v = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : (c == 2'b11) ? 5 : 0;
    if (!rst) begin
      model_reset(i);
      return;
    end
    rej_m[i] = 1'b0;
    if (ppos[i] < plen[i]) begin
      rej_m[i] = (v != 0);
      ppos[i]++;
      if (ppos[i] == plen[i]) begin plen[i] = 0; ppos[i] = 0; end
    end else if (cn) begin
      rej_m[i] = (v != 0);
      if (cred_m[i] > 0) begin
        plen[i] = 0; ppos[i] = 0;
        add_payout(i, cred_m[i]);
        cred_m[i] = 0;
      end
    end else if (v != 0) begin
      s = cred_m[i] + v;
      if (s > maxc_p[i]) rej_m[i] = 1'b1;
      else if (s >= price_p[i]) begin
        plen[i] = 0; ppos[i] = 0;
        add(i, 1'b1, 1'b0, 1'b0, s);
        if (s > price_p[i]) add_payout(i, s - price_p[i]);
        cred_m[i] = 0;
      end else cred_m[i] = s;
    end
  endtask

  task automatic step(logic [1:0] c, bit cn);
    vif0.coin = c; vif1.coin = c; vif2.coin = c;
    vif0.cancel = cn; vif1.cancel = cn; vif2.cancel = cn;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i, c, cn);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) model_reset(i);
    step(2'b00, 1'b0);
    rst = 1'b1;
  endtask

  // literal expectation checked against both the DUT and the model
  task automatic chk(string nm, int i, logic [9:0] want);
    checks += 2;
    if (obs[i] !== want) begin
      errors++;
      $display("FAIL %s dut%0d: got %h, required %h", nm, i, obs[i], want);
    end
    if (exp_vec(i) !== want) begin
      errors++;
      $display("FAIL %s model%0d: got %h, required %h", nm, i, exp_vec(i), want);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== exp_vec(i)) begin
          errors++;
          $display("FAIL cycle dut%0d at %0t: got %h, required %h", i, $time, obs[i], exp_vec(i));
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    vif0.coin = 2'b00; vif1.coin = 2'b00; vif2.coin = 2'b00;
    vif0.cancel = 1'b0; vif1.cancel = 1'b0; vif2.cancel = 1'b0;
    for (int i = 0; i < 3; i++) model_reset(i);
    #2;
    chk("reset0", 0, mk(0, 0, 0, 0, 0, 0));
    do_reset();
    cmp_en = 1'b1;

    // nickel then dime: exact price
    do_reset();
    step(2'b01, 1'b0); chk("t1_nickel", 0, mk(0, 0, 0, 0, 0, 1));
    step(2'b10, 1'b0); chk("t1_vend",   0, mk(1, 1, 0, 0, 0, 3));
    step(2'b00, 1'b0); chk("t1_idle",   0, mk(0, 0, 0, 0, 0, 0));

    // quarter: vend then one dime of change
    do_reset();
    step(2'b11, 1'b0); chk("t2_vend",  0, mk(1, 1, 0, 0, 0, 5));
    step(2'b00, 1'b0); chk("t2_dime",  0, mk(0, 1, 0, 1, 0, 2));
    step(2'b00, 1'b0); chk("t2_zero",  0, mk(0, 1, 0, 0, 0, 0));
    step(2'b00, 1'b0); chk("t2_idle",  0, mk(0, 0, 0, 0, 0, 0));

    // dime then cancel with a nickel
    do_reset();
    step(2'b10, 1'b0); chk("t3_dime",   0, mk(0, 0, 0, 0, 0, 2));
    step(2'b01, 1'b1); chk("t3_cancel", 0, mk(0, 1, 1, 1, 0, 2));
    step(2'b00, 1'b0); chk("t3_zero",   0, mk(0, 1, 0, 0, 0, 0));
    step(2'b00, 1'b0); chk("t3_idle",   0, mk(0, 0, 0, 0, 0, 0));

    // overflow rejection at PRICE=MAX=12
    do_reset();
    step(2'b11, 1'b0); chk("t4_q1",   1, mk(0, 0, 0, 0, 0, 5));
    step(2'b11, 1'b0); chk("t4_q2",   1, mk(0, 0, 0, 0, 0, 10));
    step(2'b11, 1'b0); chk("t4_rej",  1, mk(0, 0, 1, 0, 0, 10));
    step(2'b10, 1'b0); chk("t4_vend", 1, mk(1, 1, 0, 0, 0, 12));
    step(2'b00, 1'b0); chk("t4_idle", 1, mk(0, 0, 0, 0, 0, 0));

    // coins while busy are rejected
    do_reset();
    step(2'b11, 1'b0); chk("t5_vend", 0, mk(1, 1, 0, 0, 0, 5));
    step(2'b10, 1'b0); chk("t5_rej1", 0, mk(0, 1, 1, 1, 0, 2));
    step(2'b10, 1'b0); chk("t5_rej2", 0, mk(0, 1, 1, 0, 0, 0));
    step(2'b10, 1'b0); chk("t5_rej3", 0, mk(0, 0, 1, 0, 0, 0));
    step(2'b00, 1'b0); chk("t5_idle", 0, mk(0, 0, 0, 0, 0, 0));

    // asynchronous reset during payout at PRICE=1
    do_reset();
    step(2'b11, 1'b0); chk("t6_vend",  2, mk(1, 1, 0, 0, 0, 5));
    step(2'b11, 1'b0); chk("t6_rej",   2, mk(0, 1, 1, 1, 0, 4));
    step(2'b00, 1'b0); chk("t6_pay",   2, mk(0, 1, 0, 1, 0, 2));
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) model_reset(i);
    for (int i = 0; i < 3; i++) chk("t6_arst", i, mk(0, 0, 0, 0, 0, 0));
    step(2'b00, 1'b0);
    rst = 1'b1;
    step(2'b01, 1'b0); chk("t6_nickel", 2, mk(1, 1, 0, 0, 0, 1));
    step(2'b00, 1'b0); chk("t6_idle",   2, mk(0, 0, 0, 0, 0, 0));

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] c;
      bit cn;
      c  = ($urandom_range(0, 9) < 4) ? 2'b00 : 2'($urandom_range(1, 3));
      cn = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(c, cn);
    end

    step(2'b00, 1'b0);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
